// File: rtl/flip_alpha_gen.sv
// Flip-value generator: computes alpha^(k*p) for k = 1,3,5,7 at two bit positions
// in GF(2^6), GF(2^8) or GF(2^10), then holds the results until the consumer releases them.
module flip_alpha_gen (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  input  logic       i_start,
  input  logic [9:0] i_pos1,
  input  logic [9:0] i_pos2,
  input  logic       i_release,
  output logic [9:0] o_flip_alpha_S1_1,
  output logic [9:0] o_flip_alpha_S3_1,
  output logic [9:0] o_flip_alpha_S5_1,
  output logic [9:0] o_flip_alpha_S7_1,
  output logic [9:0] o_flip_alpha_S1_2,
  output logic [9:0] o_flip_alpha_S3_2,
  output logic [9:0] o_flip_alpha_S5_2,
  output logic [9:0] o_flip_alpha_S7_2,
  output logic       o_flip_alpha_valid,
  output logic       o_busy,
  output logic       o_pos_err,
  output logic [1:0] o_dbg_state
);

  // Handshake: i_start is a one-cycle request honoured only in IDLE; results are
  // valid and frozen in HOLD until i_release is sampled there (release wins over start).

  typedef enum logic [1:0] {IDLE, EXP, ODD, HOLD} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] code_q;
  logic [9:0] p1_q;
  logic [9:0] p2_q;
  logic [9:0] r1;
  logic [9:0] r2;
  logic [9:0] sq1;
  logic [9:0] sq2;
  logic [3:0] idx;
  logic [1:0] odd_cnt;

  logic [9:0] sq_e1;
  logic [9:0] sq_e2;
  logic [9:0] exp_nxt1;
  logic [9:0] exp_nxt2;
  logic [9:0] mul_b1;
  logic [9:0] mul_b2;
  logic [9:0] prod1;
  logic [9:0] prod2;
  logic [9:0] n_field;
  logic       err1;
  logic       err2;

  // Multiply by alpha, reducing by the selected primitive polynomial.
  function automatic logic [9:0] gf_xtime(input logic [9:0] a, input logic [1:0] c);
    logic [9:0] y;
    y = '0;
    case (c)
      2'b00:   y = {4'b0, a[4:0], 1'b0} ^ (a[5] ? 10'h003 : 10'h000);
      2'b01:   y = {2'b0, a[6:0], 1'b0} ^ (a[7] ? 10'h01D : 10'h000);
      default: y = {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
    endcase
    return y;
  endfunction

  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b,
                                        input logic [1:0] c);
    logic [9:0] acc;
    acc = '0;
    for (int i = 9; i >= 0; i--) begin
      acc = gf_xtime(acc, c) ^ (b[i] ? a : 10'h000);
    end
    return acc;
  endfunction

  // Squaring is linear: spread the bits to even powers, then reduce Horner-style.
  function automatic logic [9:0] gf_sqr(input logic [9:0] a, input logic [1:0] c);
    logic [18:0] s;
    logic [9:0]  acc;
    s = '0;
    for (int i = 0; i < 10; i++) begin
      s[2*i] = a[i];
    end
    acc = '0;
    for (int i = 18; i >= 0; i--) begin
      acc = gf_xtime(acc, c) ^ {9'b0, s[i]};
    end
    return acc;
  endfunction

  always_comb begin
    sq_e1    = gf_sqr(r1, code_q);
    sq_e2    = gf_sqr(r2, code_q);
    exp_nxt1 = p1_q[idx] ? gf_xtime(sq_e1, code_q) : sq_e1;
    exp_nxt2 = p2_q[idx] ? gf_xtime(sq_e2, code_q) : sq_e2;
    // First ODD cycle squares S1; later cycles multiply the running power by S1^2.
    mul_b1   = (odd_cnt == 2'd0) ? r1 : sq1;
    mul_b2   = (odd_cnt == 2'd0) ? r2 : sq2;
    prod1    = gf_mul(r1, mul_b1, code_q);
    prod2    = gf_mul(r2, mul_b2, code_q);
    case (code_q)
      2'b00:   n_field = 10'd63;
      2'b01:   n_field = 10'd255;
      default: n_field = 10'd1023;
    endcase
    err1 = (p1_q >= n_field);
    err2 = (p2_q >= n_field);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = EXP;
      EXP:     if (idx == 4'd0) state_nxt = ODD;
      ODD:     if (odd_cnt == 2'd3) state_nxt = HOLD;
      HOLD:    if (i_release) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_q             <= '0;
      p1_q               <= '0;
      p2_q               <= '0;
      r1                 <= '0;
      r2                 <= '0;
      sq1                <= '0;
      sq2                <= '0;
      idx                <= '0;
      odd_cnt            <= '0;
      o_flip_alpha_S1_1  <= '0;
      o_flip_alpha_S3_1  <= '0;
      o_flip_alpha_S5_1  <= '0;
      o_flip_alpha_S7_1  <= '0;
      o_flip_alpha_S1_2  <= '0;
      o_flip_alpha_S3_2  <= '0;
      o_flip_alpha_S5_2  <= '0;
      o_flip_alpha_S7_2  <= '0;
      o_flip_alpha_valid <= 1'b0;
      o_busy             <= 1'b0;
      o_pos_err          <= 1'b0;
    end else begin
      o_busy             <= (state_nxt != IDLE);
      o_flip_alpha_valid <= (state_nxt == HOLD);
      o_pos_err          <= (state_nxt == HOLD) && (err1 || err2);
      case (state)
        IDLE: begin
          if (i_start) begin
            code_q  <= (i_code == 2'b11) ? 2'b10 : i_code;
            p1_q    <= i_pos1;
            p2_q    <= i_pos2;
            r1      <= 10'h001;
            r2      <= 10'h001;
            idx     <= 4'd9;
            odd_cnt <= 2'd0;
          end
        end
        EXP: begin
          r1  <= exp_nxt1;
          r2  <= exp_nxt2;
          idx <= idx - 4'd1;
        end
        ODD: begin
          odd_cnt <= odd_cnt + 2'd1;
          case (odd_cnt)
            2'd0: begin
              sq1               <= prod1;
              sq2               <= prod2;
              o_flip_alpha_S1_1 <= err1 ? 10'h000 : r1;
              o_flip_alpha_S1_2 <= err2 ? 10'h000 : r2;
            end
            2'd1: begin
              r1                <= prod1;
              r2                <= prod2;
              o_flip_alpha_S3_1 <= err1 ? 10'h000 : prod1;
              o_flip_alpha_S3_2 <= err2 ? 10'h000 : prod2;
            end
            2'd2: begin
              r1                <= prod1;
              r2                <= prod2;
              o_flip_alpha_S5_1 <= err1 ? 10'h000 : prod1;
              o_flip_alpha_S5_2 <= err2 ? 10'h000 : prod2;
            end
            default: begin
              r1                <= prod1;
              r2                <= prod2;
              o_flip_alpha_S7_1 <= err1 ? 10'h000 : prod1;
              o_flip_alpha_S7_2 <= err2 ? 10'h000 : prod2;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_flip_alpha_gen.sv
// Bench for flip_alpha_gen: directed vectors plus randomized runs checked against
// a power-table field model.
module tb_flip_alpha_gen;

  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] i_code;
  logic       i_start;
  logic [9:0] i_pos1;
  logic [9:0] i_pos2;
  logic       i_release;
  logic [9:0] s1_1, s3_1, s5_1, s7_1, s1_2, s3_2, s5_2, s7_2;
  logic       valid;
  logic       busy;
  logic       pos_err;
  logic [1:0] dbg_state;
  logic [9:0] obs [8];

  int n_chk;
  int n_fail;
  logic [9:0] exp_q [$];

  flip_alpha_gen dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_code             (i_code),
    .i_start            (i_start),
    .i_pos1             (i_pos1),
    .i_pos2             (i_pos2),
    .i_release          (i_release),
    .o_flip_alpha_S1_1  (s1_1),
    .o_flip_alpha_S3_1  (s3_1),
    .o_flip_alpha_S5_1  (s5_1),
    .o_flip_alpha_S7_1  (s7_1),
    .o_flip_alpha_S1_2  (s1_2),
    .o_flip_alpha_S3_2  (s3_2),
    .o_flip_alpha_S5_2  (s5_2),
    .o_flip_alpha_S7_2  (s7_2),
    .o_flip_alpha_valid (valid),
    .o_busy             (busy),
    .o_pos_err          (pos_err),
    .o_dbg_state        (dbg_state)
  );

  assign obs[0] = s1_1;
  assign obs[1] = s3_1;
  assign obs[2] = s5_1;
  assign obs[3] = s7_1;
  assign obs[4] = s1_2;
  assign obs[5] = s3_2;
  assign obs[6] = s5_2;
  assign obs[7] = s7_2;

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: alpha^e from a table built by repeated multiplication by x.
  function automatic int field_n(input int code);
    case (code)
      0:       return 63;
      1:       return 255;
      default: return 1023;
    endcase
  endfunction

  function automatic logic [9:0] ref_pow(input int code, input int p, input int k);
    int m, poly, n, e, v;
    case (code)
      0:       begin m = 6;  poly = 'h43;  end
      1:       begin m = 8;  poly = 'h11D; end
      default: begin m = 10; poly = 'h409; end
    endcase
    n = (1 << m) - 1;
    if (p >= n) return 10'h000;
    e = (k * p) % n;
    v = 1;
    for (int i = 0; i < e; i++) begin
      v = v << 1;
      if ((v & (1 << m)) != 0) v = v ^ poly;
    end
    return 10'(v);
  endfunction

  // Driver: one full computation with latency and value checks.
  // Entered and left at 1 time unit after a rising edge, DUT idle on entry.
  task automatic do_op(input logic [1:0] code, input logic [9:0] p1, input logic [9:0] p2,
                       input int noise_cyc, input string name);
    int cyc;
    int pk;
    logic [9:0] e;
    logic ee;
    i_code  = code;
    i_pos1  = p1;
    i_pos2  = p2;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_code  = 2'($urandom_range(0, 3));
    i_pos1  = 10'($urandom_range(0, 1023));
    i_pos2  = 10'($urandom_range(0, 1023));
    n_chk++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_busy: busy=%b valid=%b required busy=1 valid=0", name, busy, valid);
    end
    cyc = 0;
    while (valid !== 1'b1 && cyc < 40) begin
      i_start   = (cyc == noise_cyc);
      i_release = (cyc == noise_cyc);
      @(posedge i_clk); #1;
      cyc++;
    end
    i_start   = 1'b0;
    i_release = 1'b0;
    n_chk++;
    if (cyc !== 14) begin
      n_fail++;
      $display("FAIL %s latency: valid after %0d edges, required 14", name, cyc);
    end
    for (int pos = 0; pos < 2; pos++) begin
      pk = (pos == 0) ? int'(p1) : int'(p2);
      exp_q.push_back(ref_pow(int'(code), pk, 1));
      exp_q.push_back(ref_pow(int'(code), pk, 3));
      exp_q.push_back(ref_pow(int'(code), pk, 5));
      exp_q.push_back(ref_pow(int'(code), pk, 7));
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs[i] !== e) begin
        n_fail++;
        $display("FAIL %s value[%0d] code=%0d p1=%0d p2=%0d: got %h required %h",
                 name, i, code, p1, p2, obs[i], e);
      end
    end
    ee = (int'(p1) >= field_n(int'(code))) || (int'(p2) >= field_n(int'(code)));
    n_chk++;
    if (pos_err !== ee) begin
      n_fail++;
      $display("FAIL %s pos_err: got %b required %b", name, pos_err, ee);
    end
  endtask

  task automatic do_release(input string name);
    i_release = 1'b1;
    @(posedge i_clk); #1;
    i_release = 1'b0;
    n_chk++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: valid=%b busy=%b required 0 0", name, valid, busy);
    end
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    i_code    = 2'b00;
    i_start   = 1'b0;
    i_pos1    = '0;
    i_pos2    = '0;
    i_release = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (obs[i] !== 10'h000) begin
        n_fail++;
        $display("FAIL reset value[%0d]: got %h required 000", i, obs[i]);
      end
    end
    n_chk++;
    if (valid !== 1'b0 || busy !== 1'b0 || pos_err !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset flags: valid=%b busy=%b pos_err=%b state=%0d required all 0",
               valid, busy, pos_err, dbg_state);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_spec_vectors();
    do_op(2'b00, 10'd6, 10'd0, -1, "gf64_p6_p0");
    n_chk++;
    if (s1_1 !== 10'h003 || s3_1 !== 10'h00F || s1_2 !== 10'h001 || s3_2 !== 10'h001 ||
        s5_2 !== 10'h001 || s7_2 !== 10'h001) begin
      n_fail++;
      $display("FAIL gf64_p6_p0 const: S1_1=%h S3_1=%h pos2=%h %h %h %h required 003 00F 001x4",
               s1_1, s3_1, s1_2, s3_2, s5_2, s7_2);
    end
    do_release("gf64_p6_p0");
    do_op(2'b10, 10'd10, 10'd1, -1, "gf1024_p10_p1");
    n_chk++;
    if (s1_1 !== 10'h009 || s3_1 !== 10'h249 || s1_2 !== 10'h002 || s3_2 !== 10'h008) begin
      n_fail++;
      $display("FAIL gf1024_p10_p1 const: %h %h %h %h required 009 249 002 008",
               s1_1, s3_1, s1_2, s3_2);
    end
    do_release("gf1024_p10_p1");
    do_op(2'b00, 10'd63, 10'd5, -1, "gf64_err");
    n_chk++;
    if (pos_err !== 1'b1 || s1_1 !== 10'h000 || s3_1 !== 10'h000 || s5_1 !== 10'h000 ||
        s7_1 !== 10'h000 || s1_2 !== 10'h020) begin
      n_fail++;
      $display("FAIL gf64_err const: pos_err=%b pos1=%h %h %h %h S1_2=%h required 1 0000 020",
               pos_err, s1_1, s3_1, s5_1, s7_1, s1_2);
    end
    do_release("gf64_err");
  endtask

  task automatic test_hold();
    logic [9:0] p2;
    logic [9:0] want [8];
    int bad;
    p2 = 10'($urandom_range(0, 254));
    do_op(2'b01, 10'd8, p2, -1, "hold");
    n_chk++;
    if (s1_1 !== 10'h01D) begin
      n_fail++;
      $display("FAIL hold S1_1: got %h required 01D", s1_1);
    end
    for (int i = 0; i < 4; i++) begin
      want[i]     = ref_pow(1, 8, 2 * i + 1);
      want[i + 4] = ref_pow(1, int'(p2), 2 * i + 1);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      bad = 0;
      for (int i = 0; i < 8; i++) if (obs[i] !== want[i]) bad++;
      n_chk++;
      if (bad != 0 || valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold cycle %0d: %0d values wrong, valid=%b busy=%b required 0 1 1",
                 c, bad, valid, busy);
      end
    end
    do_release("hold");
  endtask

  task automatic test_hold_start();
    logic [9:0] p1, p2;
    logic [9:0] want [8];
    int bad;
    p1 = 10'($urandom_range(0, 1022));
    p2 = 10'($urandom_range(0, 1022));
    do_op(2'b11, p1, p2, -1, "hold_start");
    for (int i = 0; i < 4; i++) begin
      want[i]     = ref_pow(2, int'(p1), 2 * i + 1);
      want[i + 4] = ref_pow(2, int'(p2), 2 * i + 1);
    end
    i_start = 1'b1;
    i_code  = 2'b00;
    i_pos1  = 10'd3;
    i_pos2  = 10'd4;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    bad = 0;
    for (int i = 0; i < 8; i++) if (obs[i] !== want[i]) bad++;
    n_chk++;
    if (bad != 0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_start ignored: %0d values changed, valid=%b required 0 1", bad, valid);
    end
    i_start   = 1'b1;
    i_release = 1'b1;
    @(posedge i_clk); #1;
    i_start   = 1'b0;
    i_release = 1'b0;
    n_chk++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_and_start: valid=%b busy=%b required 0 0", valid, busy);
    end
    for (int c = 0; c < 16; c++) begin
      @(posedge i_clk); #1;
      n_chk++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL release_and_start idle cycle %0d: valid=%b busy=%b required 0 0",
                 c, valid, busy);
      end
    end
  endtask

  task automatic test_release_outside();
    i_release = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      n_chk++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL release_idle: valid=%b busy=%b required 0 0", valid, busy);
      end
    end
    i_release = 1'b0;
    do_op(2'b01, 10'd200, 10'd17, 4, "noise_exp");
    do_release("noise_exp");
    do_op(2'b10, 10'd1000, 10'd513, 12, "noise_odd");
    do_release("noise_odd");
  endtask

  task automatic test_mid_reset();
    int bad;
    i_code  = 2'b10;
    i_pos1  = 10'd777;
    i_pos2  = 10'd3;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (7) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 8; i++) if (obs[i] !== 10'h000) bad++;
    n_chk++;
    if (bad != 0 || valid !== 1'b0 || busy !== 1'b0 || pos_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_exp: %0d values nonzero valid=%b busy=%b pos_err=%b required 0",
               bad, valid, busy, pos_err);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    do_op(2'b00, 10'd62, 10'd100, -1, "after_reset");
    #2;
    i_rst_n = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 8; i++) if (obs[i] !== 10'h000) bad++;
    n_chk++;
    if (bad != 0 || valid !== 1'b0 || busy !== 1'b0 || pos_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_hold: %0d values nonzero valid=%b busy=%b pos_err=%b required 0",
               bad, valid, busy, pos_err);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    do_op(2'b01, 10'd0, 10'd254, -1, "after_reset_hold");
    do_release("after_reset_hold");
  endtask

  task automatic test_random();
    logic [1:0] code;
    logic [9:0] p1, p2;
    int n;
    for (int t = 0; t < 24; t++) begin
      code = 2'($urandom_range(0, 3));
      n    = field_n(int'(code));
      p1 = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(n, 1023)) : 10'($urandom_range(0, n - 1));
      p2 = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(n, 1023)) : 10'($urandom_range(0, n - 1));
      do_op(code, p1, p2, $urandom_range(0, 16) - 2, "random");
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      #0;
      do_release("random");
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_spec_vectors();
    test_hold();
    test_hold_start();
    test_release_outside();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
